// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris input stage: button indices, channel
// FSM encoding, default 50 MHz timing and small width helpers.
package tetris_pkg;

  // Button channel indices
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DOWN  = 2;

  // Channel repeat-FSM encoding
  typedef logic [1:0] chan_state_t;
  localparam chan_state_t ST_IDLE   = 2'd0;
  localparam chan_state_t ST_DELAY  = 2'd1;
  localparam chan_state_t ST_REPEAT = 2'd2;

  // Default timing for a 50 MHz clock
  localparam int NUM_BTN_DEF         = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;    // 10 ms
  localparam int REPEAT_DELAY_DEF    = 15000000;  // 300 ms
  localparam int REPEAT_PERIOD_DEF   = 5000000;   // 100 ms

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debounce counter and the
// hold-to-repeat FSM. pulse_next is the unmasked pulse that the top level
// registers on the same edge that level rises.
module btn_channel
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic pulse_next
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int TM_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DELAY_LOAD  = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] PERIOD_LOAD = TM_W'(REPEAT_PERIOD - 1);

  logic [1:0]      sync_q;
  logic            btn_sync;
  logic [DB_W-1:0] db_cnt;
  logic            differs;
  logic            db_done;
  logic            level_rise;
  chan_state_t     state_q, state_d;
  logic [TM_W-1:0] timer_q, timer_d;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would collapse the chain.
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], btn_raw};
  end

  assign btn_sync   = sync_q[1];
  assign differs    = btn_sync ^ level;
  assign db_done    = differs && (db_cnt == DB_LAST);
  assign level_rise = db_done && !level;

  // Debounce: count consecutive differing cycles, toggle level on the last one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      if (!differs || db_done) db_cnt <= '0;
      else                     db_cnt <= db_cnt + 1'b1;
      if (db_done) level <= ~level;
    end
  end

  // Repeat FSM state and timer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Repeat FSM next state; a released button wins over timer expiry
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (level_rise) begin
          state_d = ST_DELAY;
          timer_d = DELAY_LOAD;
        end
      end
      ST_DELAY: begin
        if (!level) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          state_d = ST_REPEAT;
          timer_d = PERIOD_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!level) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          timer_d = PERIOD_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Pulse request: on the debounced rise, then on each timer expiry while held
  always_comb begin
    pulse_next = 1'b0;
    case (state_q)
      ST_IDLE:              pulse_next = level_rise;
      ST_DELAY, ST_REPEAT:  pulse_next = level && (timer_q == '0);
      default:              pulse_next = 1'b0;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Tetris push-button front end: one conditioned channel per button, then a
// freeze mask and LEFT/RIGHT conflict drop before the registered move pulses.
module button_conditioner
  import tetris_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic               frz,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  logic [NUM_BTN-1:0] raw_pulse;
  logic [NUM_BTN-1:0] lr_bits;
  logic [NUM_BTN-1:0] pulse_d;
  logic               lr_conflict;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_in[i]),
      .level      (btn_level[i]),
      .pulse_next (raw_pulse[i])
    );
    assign lr_bits[i] = (i == BTN_LEFT) || (i == BTN_RIGHT);
  end

  if (NUM_BTN > BTN_RIGHT) begin : g_lr
    assign lr_conflict = raw_pulse[BTN_LEFT] & raw_pulse[BTN_RIGHT];
  end else begin : g_no_lr
    assign lr_conflict = 1'b0;
  end

  // Drop coincident LEFT+RIGHT moves; freeze suppresses every move
  always_comb begin
    pulse_d = raw_pulse & ~(lr_bits & {NUM_BTN{lr_conflict}});
    if (frz) pulse_d = '0;
  end

  // Registered move strobes, aligned with the debounced level edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_pulse <= '0;
    else      btn_pulse <= pulse_d;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short timing constants.
// The reference model works from the behavioural rules: level flips after
// DEB consecutive differing synchronised samples, and pulses fall on the
// rise edge and then every RD, RD+RP, RD+2*RP... cycles while held.
module tb_button_conditioner;

  localparam int NB  = 3;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic          frz = 1'b0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NB-1:0] h0, h1;
  logic [NB-1:0] m_level;
  logic [NB-1:0] exp_pulse;
  int            run [NB];
  int            rise_edge [NB];
  int            edge_cnt;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .frz       (frz),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    h0 = '0; h1 = '0; m_level = '0; exp_pulse = '0; edge_cnt = 0;
    for (int c = 0; c < NB; c++) begin
      run[c] = 0;
      rise_edge[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [NB-1:0] s, p;
    logic          old;
    int            k;
    s = h1;
    p = '0;
    edge_cnt++;
    for (int c = 0; c < NB; c++) begin
      old = m_level[c];
      if (s[c] !== old) run[c]++;
      else              run[c] = 0;
      if (run[c] == DEB) begin
        m_level[c] = ~old;
        run[c] = 0;
      end
      if (!old && m_level[c]) begin
        rise_edge[c] = edge_cnt;
        p[c] = 1'b1;
      end else if (old) begin
        k = edge_cnt - rise_edge[c];
        if (k >= RD && ((k - RD) % RP) == 0) p[c] = 1'b1;
      end
    end
    if (p[0] && p[1]) p[1:0] = 2'b00;
    if (frz) p = '0;
    exp_pulse = p;
    h1 = h0;
    h0 = btn_in;
  endtask

  // Advance one clock, update the model, settle past the edge
  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_in = 3'b111;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (btn_level !== 3'b000) begin
        errors++;
        $display("FAIL reset_level cyc %0d: got %b expected 000", i, btn_level);
      end
      checks++;
      if (btn_pulse !== 3'b000) begin
        errors++;
        $display("FAIL reset_pulse cyc %0d: got %b expected 000", i, btn_pulse);
      end
    end
    btn_in = '0;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (btn_level !== m_level || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL reset_release cyc %0d: got lvl %b pls %b expected lvl %b pls %b",
                 i, btn_level, btn_pulse, m_level, exp_pulse);
      end
    end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    btn_in[0] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 3) btn_in[0] = 1'b0;
      seen |= btn_level[0] | btn_pulse[0];
      checks++;
      if (btn_level !== m_level || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL glitch cyc %0d: got lvl %b pls %b expected lvl %b pls %b",
                 i, btn_level, btn_pulse, m_level, exp_pulse);
      end
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: got activity %b expected 0", seen);
    end
  endtask

  task automatic test_single_press();
    int rise_at, npulse, pulse_at;
    rise_at = -1; npulse = 0; pulse_at = -1;
    btn_in[2] = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 8) btn_in[2] = 1'b0;
      if (btn_level[2] && rise_at < 0) rise_at = i;
      if (btn_pulse[2]) begin
        npulse++;
        pulse_at = i;
      end
      checks++;
      if (btn_level !== m_level || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL single cyc %0d: got lvl %b pls %b expected lvl %b pls %b",
                 i, btn_level, btn_pulse, m_level, exp_pulse);
      end
    end
    checks++;
    if (rise_at != DEB + 2) begin
      errors++;
      $display("FAIL single_latency: got %0d expected %0d", rise_at, DEB + 2);
    end
    checks++;
    if (npulse != 1 || pulse_at != DEB + 2) begin
      errors++;
      $display("FAIL single_pulse: got count %0d at %0d expected 1 at %0d",
               npulse, pulse_at, DEB + 2);
    end
  endtask

  task automatic test_hold_repeat();
    int got[$];
    int want[$];
    int rise, fall, late;
    rise = DEB + 2;
    fall = 40 + DEB + 2;
    late = 0;
    for (int e = 1; e <= 64; e++)
      if (e == rise || (e > rise && e <= fall && (e - rise) >= RD && ((e - rise - RD) % RP) == 0))
        want.push_back(e);
    btn_in[1] = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 40) btn_in[1] = 1'b0;
      if (btn_pulse[1]) got.push_back(i);
      if (i > fall && btn_pulse[1]) late++;
      checks++;
      if (btn_level !== m_level || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL hold cyc %0d: got lvl %b pls %b expected lvl %b pls %b",
                 i, btn_level, btn_pulse, m_level, exp_pulse);
      end
    end
    checks++;
    if (got.size() != want.size()) begin
      errors++;
      $display("FAIL hold_count: got %0d expected %0d", got.size(), want.size());
    end else begin
      for (int j = 0; j < want.size(); j++) begin
        checks++;
        if (got[j] != want[j]) begin
          errors++;
          $display("FAIL hold_time[%0d]: got %0d expected %0d", j, got[j], want[j]);
        end
      end
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL hold_after_release: got %0d pulses expected 0", late);
    end
  endtask

  task automatic test_freeze();
    int frozen_pulses, first_after, want_first;
    frozen_pulses = 0; first_after = -1; want_first = -1;
    for (int e = 21; e <= 40 && want_first < 0; e++)
      if ((e - (DEB + 2)) >= RD && ((e - (DEB + 2) - RD) % RP) == 0) want_first = e;
    frz = 1'b1;
    btn_in[2] = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      step();
      if (i <= 20 && btn_pulse[2]) frozen_pulses++;
      if (i > 20 && btn_pulse[2] && first_after < 0) first_after = i;
      if (i == 20) frz = 1'b0;
      if (i == 30) btn_in[2] = 1'b0;
      checks++;
      if (btn_level !== m_level || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL freeze cyc %0d: got lvl %b pls %b expected lvl %b pls %b",
                 i, btn_level, btn_pulse, m_level, exp_pulse);
      end
    end
    checks++;
    if (frozen_pulses != 0) begin
      errors++;
      $display("FAIL freeze_mask: got %0d pulses expected 0", frozen_pulses);
    end
    checks++;
    if (first_after != want_first) begin
      errors++;
      $display("FAIL freeze_grid: got first pulse %0d expected %0d", first_after, want_first);
    end
    for (int i = 0; i < 14; i++) step();
  endtask

  task automatic test_conflict();
    int lr_pulses, down_pulses, want_down;
    logic [1:0] lvl_at_rise;
    lr_pulses = 0; down_pulses = 0; want_down = 0;
    lvl_at_rise = '0;
    for (int e = 1; e <= 30; e++)
      if (e == DEB + 2 || (e > DEB + 2 && (e - DEB - 2) >= RD && ((e - DEB - 2 - RD) % RP) == 0))
        want_down++;
    btn_in = 3'b111;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == DEB + 2) lvl_at_rise = btn_level[1:0];
      if (btn_pulse[1:0] != 2'b00) lr_pulses++;
      if (btn_pulse[2]) down_pulses++;
      checks++;
      if (btn_level !== m_level || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL conflict cyc %0d: got lvl %b pls %b expected lvl %b pls %b",
                 i, btn_level, btn_pulse, m_level, exp_pulse);
      end
    end
    checks++;
    if (lvl_at_rise !== 2'b11) begin
      errors++;
      $display("FAIL conflict_level: got %b expected 11", lvl_at_rise);
    end
    checks++;
    if (lr_pulses != 0) begin
      errors++;
      $display("FAIL conflict_drop: got %0d LR pulses expected 0", lr_pulses);
    end
    checks++;
    if (down_pulses != want_down) begin
      errors++;
      $display("FAIL conflict_down: got %0d expected %0d", down_pulses, want_down);
    end
    btn_in = '0;
    for (int i = 0; i < 14; i++) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 11) == 0) btn_in[c] = ~btn_in[c];
      if ($urandom_range(0, 24) == 0) frz = ~frz;
      step();
      checks++;
      if (btn_level !== m_level || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL random cyc %0d: got lvl %b pls %b expected lvl %b pls %b",
                 i, btn_level, btn_pulse, m_level, exp_pulse);
      end
    end
    btn_in = '0;
    frz = 1'b0;
    for (int i = 0; i < 24; i++) step();
  endtask

  task automatic test_async_reset();
    int waited;
    waited = 0;
    btn_in[2] = 1'b1;
    step();
    while (!exp_pulse[2] && waited < 20) begin
      step();
      waited++;
    end
    checks++;
    if (btn_pulse !== exp_pulse || btn_level !== m_level || !exp_pulse[2]) begin
      errors++;
      $display("FAIL async_pre: got lvl %b pls %b expected lvl %b pls %b (waited %0d)",
               btn_level, btn_pulse, m_level, exp_pulse, waited);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (btn_level !== 3'b000 || btn_pulse !== 3'b000) begin
      errors++;
      $display("FAIL async_clear: got lvl %b pls %b expected 000 000", btn_level, btn_pulse);
    end
    model_reset();
    btn_in = '0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (btn_level !== m_level || btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL async_release cyc %0d: got lvl %b pls %b expected lvl %b pls %b",
                 i, btn_level, btn_pulse, m_level, exp_pulse);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_single_press();
    test_hold_repeat();
    test_freeze();
    test_conflict();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the Tetris game logic.
- Takes the raw asynchronous push-buttons (LEFT, RIGHT, DOWN) and synchronises and debounces them.
- Produces per-button debounced levels plus single-cycle move pulses with hold-to-repeat.
- The VGA/game block consumes the pulses as move commands. The FRZ switch gates pulse generation so no moves are issued while the game is frozen.

Parameters:
- NUM_BTN, 3, number of button channels; bit 0 = LEFT, 1 = RIGHT, 2 = DOWN.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
- REPEAT_DELAY, 15000000, hold cycles from the first pulse to the first auto-repeat pulse (300 ms).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (100 ms).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset; asserted when 0.
- btn_in, input, NUM_BTN, raw asynchronous buttons, active-high.
- frz, input, 1, synchronous freeze; when 1, btn_pulse is forced to 0.
- btn_level, output, NUM_BTN, debounced button levels.
- btn_pulse, output, NUM_BTN, one-cycle move strobes.

Behaviour:
- Reset (rst=0, asynchronous): all state clears immediately.
  - Synchroniser flops, debounce counters and timers go to 0.
  - Channel FSMs go to IDLE.
  - btn_level=0 and btn_pulse=0.
  - Deassertion takes effect on the next clk edge.
- Synchroniser: two-flop chain per bit. Raw btn_in is never used elsewhere.
- Debounce, per channel:
  - Counter increments while the synchronised value differs from btn_level.
  - Counter clears to 0 on any cycle the values match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and still differs, btn_level toggles on that edge and the counter clears.
  - Net latency from a clean input edge to btn_level change is DEBOUNCE_CYCLES+2 cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_level.
- Channel FSM states:
  - IDLE: on btn_level rising, emit a pulse in the same cycle btn_level becomes 1, load the timer with REPEAT_DELAY-1, go to DELAY.
  - DELAY: timer decrements. At 0 with the level still 1, emit a pulse, load REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: timer decrements. At 0, emit a pulse and reload REPEAT_PERIOD-1.
  - From DELAY or REPEAT: btn_level=0 returns to IDLE on the next edge with no pulse. Release takes priority over a coincident timer expiry.
- Pulse timing:
  - btn_pulse is registered and high for exactly one cycle per event.
  - Pulse spacing: first-to-second is REPEAT_DELAY cycles; later pulses are REPEAT_PERIOD cycles apart.
- Freeze:
  - frz=1 masks btn_pulse to 0.
  - Debounce, FSM and timers keep running, so no backlog accumulates and no burst appears on unfreeze.
  - btn_level is not masked.
- LEFT/RIGHT conflict: if both channels would pulse in the same cycle, both LEFT and RIGHT pulses are dropped that cycle; DOWN is unaffected.
- Channels are otherwise independent. Simultaneous DOWN and LEFT pulses are legal.
- Timer width: $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)). Debounce counter width: $clog2(DEBOUNCE_CYCLES). No wrap-around is permitted; counters saturate by construction of the reload and clear rules.

Decomposition:
- Shared package (tetris_pkg) holds:
  - button index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_DOWN=2;
  - channel FSM state encoding (IDLE, DELAY, REPEAT) as localparams;
  - default timing constants for a 50 MHz clock.
- One sub-module, btn_channel: synchroniser, debounce and repeat FSM for a single button, outputting its level and raw pulse.
- button_conditioner instantiates NUM_BTN copies, then applies the frz mask and the LEFT/RIGHT conflict rule.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: hold rst=0 with btn_in=3'b111 for 5 cycles, release -> btn_level=0 and btn_pulse=0 throughout reset. Dropping rst mid-run clears outputs without waiting for a clk edge.
- Glitch reject: btn_in[0] high for 3 cycles then low -> btn_level[0] and btn_pulse[0] never assert.
- Single press: btn_in[2] high for 8 cycles -> btn_level[2] rises 6 cycles after the edge, btn_pulse[2] is high exactly that cycle, with no further pulse.
- Hold repeat: btn_in[1] held for 40 cycles -> pulses at t0, t0+10, t0+13, t0+16, ... until release. After release plus debounce, no pulses and the FSM is in IDLE.
- Freeze: hold btn_in[2] with frz=1 for 20 cycles, then frz=0 -> zero pulses while frozen. The next pulse lands on the original REPEAT_PERIOD grid, not immediately.
- Conflict: btn_in[0] and btn_in[1] rise in the same cycle -> both btn_level bits set, btn_pulse[1:0] stays 0 on coincident cycles, and btn_pulse[2] is unaffected.
